// File: rtl/cpu_pkg.sv
// Shared writeback-stage types and constants.
// Fields are sized at the default widths; narrower instances zero-pad into them.
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic                  regwrite;
        logic                  memtoreg;
        logic                  jumplink;
        logic [DATA_W_DEF-1:0] rd;
        logic [DATA_W_DEF-1:0] aluout;
        logic [DATA_W_DEF-1:0] pcplus4;
        logic [ADDR_W_DEF-1:0] writereg;
    } wb_fields_t;

endpackage

// File: rtl/wb_stage_slot.sv
// One writeback stage register: 1 cycle, holds on stall_i.
// flush_i clears valid/regwrite of whatever the slot would hold next, stalled or not.
module wb_stage_slot
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stall_i,
    input  logic       flush_i,
    input  wb_fields_t d_i,
    output wb_fields_t q_o
);

    wb_fields_t slot_d;
    wb_fields_t slot_q;

    always_comb begin
        slot_d = stall_i ? slot_q : d_i;
        if (flush_i) begin
            slot_d.valid    = 1'b0;
            slot_d.regwrite = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign q_o = slot_q;

endmodule

// File: rtl/wb_pipe_stage.sv
// MEM->WB pipeline of DEPTH stages with result select, forwarding match and retire counter.
// Latency DEPTH edges; stall freezes every stage, flush kills the stage-0 slot.
module wb_pipe_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              validm,
    input  logic              regwritem,
    input  logic              memtoregm,
    input  logic              jumplinkm,
    input  logic [DATA_W-1:0] rdm,
    input  logic [DATA_W-1:0] aluoutm,
    input  logic [DATA_W-1:0] pcplus4m,
    input  logic [ADDR_W-1:0] writeregm,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              validw,
    output logic              regwritew,
    output logic [ADDR_W-1:0] writeregw,
    output logic [DATA_W-1:0] resultw,
    output logic              fwd_rs,
    output logic              fwd_rt,
    output logic [CNT_W-1:0]  retired
);

    if (DEPTH < 1 || DEPTH > 4) begin : g_depth_chk
        $error("wb_pipe_stage: DEPTH must be in 1..4");
    end
    if (DATA_W > DATA_W_DEF || ADDR_W > ADDR_W_DEF) begin : g_width_chk
        $error("wb_pipe_stage: DATA_W/ADDR_W exceed the wb_fields_t widths");
    end

    wb_fields_t            cap_d;
    wb_fields_t            stage_q [DEPTH];
    wb_fields_t            fin;
    logic [DATA_W_DEF-1:0] result_full;
    logic [CNT_W-1:0]      retired_d;
    logic [CNT_W-1:0]      retired_q;

    // Flush is applied inside the head slot so it also works while stalled.
    always_comb begin
        cap_d          = '0;
        cap_d.valid    = validm;
        cap_d.memtoreg = memtoregm;
        cap_d.jumplink = jumplinkm;
        cap_d.rd       = DATA_W_DEF'(rdm);
        cap_d.aluout   = DATA_W_DEF'(aluoutm);
        cap_d.pcplus4  = DATA_W_DEF'(pcplus4m);
        cap_d.writereg = ADDR_W_DEF'(writeregm);
        cap_d.regwrite = regwritem & validm & (cap_d.writereg != REG_ZERO);
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            wb_stage_slot u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .stall_i (stall),
                .flush_i (flush),
                .d_i     (cap_d),
                .q_o     (stage_q[0])
            );
        end else begin : g_tail
            wb_stage_slot u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .stall_i (stall),
                .flush_i (1'b0),
                .d_i     (stage_q[k-1]),
                .q_o     (stage_q[k])
            );
        end
    end

    assign fin = stage_q[DEPTH-1];

    always_comb begin
        result_full = fin.jumplink ? fin.pcplus4 : (fin.memtoreg ? fin.rd : fin.aluout);
    end

    assign validw    = fin.valid;
    assign regwritew = fin.regwrite & fin.valid;
    assign writeregw = fin.writereg[ADDR_W-1:0];
    assign resultw   = result_full[DATA_W-1:0];
    assign fwd_rs    = regwritew & (writeregw == rs_addr) & (rs_addr != '0);
    assign fwd_rt    = regwritew & (writeregw == rt_addr) & (rt_addr != '0);

    assign retired_d = (fin.valid && !stall) ? retired_q + CNT_W'(1) : retired_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Random + directed stimulus against a queue-based reference model of the writeback pipe.
module tb_wb_pipe_stage;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 3;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          validm = 1'b0;
    logic          regwritem = 1'b0;
    logic          memtoregm = 1'b0;
    logic          jumplinkm = 1'b0;
    logic [DW-1:0] rdm = '0;
    logic [DW-1:0] aluoutm = '0;
    logic [DW-1:0] pcplus4m = '0;
    logic [AW-1:0] writeregm = '0;
    logic [AW-1:0] rs_addr = '0;
    logic [AW-1:0] rt_addr = '0;
    logic          validw;
    logic          regwritew;
    logic [AW-1:0] writeregw;
    logic [DW-1:0] resultw;
    logic          fwd_rs;
    logic          fwd_rt;
    logic [CW-1:0] retired;

    wb_pipe_stage #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .flush     (flush),
        .validm    (validm),
        .regwritem (regwritem),
        .memtoregm (memtoregm),
        .jumplinkm (jumplinkm),
        .rdm       (rdm),
        .aluoutm   (aluoutm),
        .pcplus4m  (pcplus4m),
        .writeregm (writeregm),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .validw    (validw),
        .regwritew (regwritew),
        .writeregw (writeregw),
        .resultw   (resultw),
        .fwd_rs    (fwd_rs),
        .fwd_rt    (fwd_rt),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    // An in-flight instruction: what it must produce, and how many
    // unstalled edges it has seen since entering the pipe.
    typedef struct {
        logic          rw;
        logic [AW-1:0] wr;
        logic [DW-1:0] res;
        int            pos;
    } exp_t;

    exp_t          q[$];
    int            nvec = 0;
    int            nerr = 0;
    logic [CW-1:0] exp_ret = '0;
    bit            done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic v, input logic rw, input logic m, input logic j,
                         input logic [DW-1:0] rd, input logic [DW-1:0] alu,
                         input logic [DW-1:0] pc, input logic [AW-1:0] wr,
                         input logic st, input logic fl);
        exp_t e;
        #1;
        validm    = v;
        regwritem = rw;
        memtoregm = m;
        jumplinkm = j;
        rdm       = rd;
        aluoutm   = alu;
        pcplus4m  = pc;
        writeregm = wr;
        stall     = st;
        flush     = fl;
        rs_addr   = AW'($urandom_range(0, 7));
        rt_addr   = AW'($urandom_range(0, 7));
        @(posedge clk);
        if (!st) begin
            foreach (q[i]) q[i].pos++;
            if (v && !fl) begin
                e.rw  = rw && (wr != 0);
                e.wr  = wr;
                e.res = j ? pc : (m ? rd : alu);
                e.pos = 0;
                q.push_back(e);
            end
        end else if (fl && q.size() > 0 && q[$].pos == 0) begin
            void'(q.pop_back());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic rand_op(input logic st, input logic fl);
        apply(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
              AW'($urandom_range(0, 7)), st, fl);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_validw"},    64'(validw),    64'(0));
        check({tag, "_regwritew"}, 64'(regwritew), 64'(0));
        check({tag, "_resultw"},   64'(resultw),   64'(0));
        check({tag, "_writeregw"}, 64'(writeregw), 64'(0));
        check({tag, "_retired"},   64'(retired),   64'(0));
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   vis;
        if (rst_n && !done) begin
            vis = (q.size() > 0) && (q[0].pos == DEPTH - 1);
            check("validw", 64'(validw), 64'(vis));
            check("retired", 64'(retired), 64'(exp_ret));
            if (vis) begin
                e = q[0];
                check("regwritew", 64'(regwritew), 64'(e.rw));
                check("writeregw", 64'(writeregw), 64'(e.wr));
                check("resultw", 64'(resultw), 64'(e.res));
                check("fwd_rs", 64'(fwd_rs), 64'(e.rw && e.wr == rs_addr && rs_addr != 0));
                check("fwd_rt", 64'(fwd_rt), 64'(e.rw && e.wr == rt_addr && rt_addr != 0));
                if (!stall) begin
                    void'(q.pop_front());
                    exp_ret++;
                end
            end else begin
                check("bubble_regwritew", 64'(regwritew), 64'(0));
                check("bubble_fwd_rs", 64'(fwd_rs), 64'(0));
                check("bubble_fwd_rt", 64'(fwd_rt), 64'(0));
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #20;
        check_reset_outputs("por");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);

        // Result select: aluout / rd / pcplus4 / pcplus4 (jumplink wins).
        apply(1'b1, 1'b1, 1'b0, 1'b0, 32'h22, 32'h11, 32'h33, 5'd9, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b1, 1'b0, 32'h22, 32'h11, 32'h33, 5'd9, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b0, 1'b1, 32'h22, 32'h11, 32'h33, 5'd9, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 32'h22, 32'h11, 32'h33, 5'd9, 1'b0, 1'b0);
        idle(DEPTH + 1);

        // Register zero never written; a bubble neither writes nor retires.
        apply(1'b1, 1'b1, 1'b0, 1'b0, '0, 32'hAA, '0, 5'd0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, '0, 32'hBB, '0, 5'd5, 1'b0, 1'b0);
        idle(DEPTH + 1);

        // Stall two cycles mid-stream, then flush while stalled, then flush while running.
        rand_op(1'b0, 1'b0);
        rand_op(1'b0, 1'b0);
        rand_op(1'b1, 1'b0);
        rand_op(1'b1, 1'b0);
        rand_op(1'b0, 1'b0);
        rand_op(1'b1, 1'b1);
        rand_op(1'b0, 1'b1);
        rand_op(1'b0, 1'b0);
        idle(DEPTH + 3);

        // Asynchronous reset between edges with instructions in flight.
        rand_op(1'b0, 1'b0);
        rand_op(1'b0, 1'b0);
        rand_op(1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        q.delete();
        exp_ret = '0;
        rst_n = 1'b1;
        rand_op(1'b0, 1'b0);
        idle(DEPTH + 1);

        // Random traffic; the 4-bit counter wraps many times.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) < 75)
                rand_op(1'($urandom_range(0, 99) < 20), 1'($urandom_range(0, 99) < 10));
            else
                apply(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
                      $urandom, AW'($urandom_range(0, 7)),
                      1'($urandom_range(0, 99) < 20), 1'($urandom_range(0, 99) < 10));
        end
        idle(DEPTH + 3);
        check("drained", 64'(q.size()), 64'(0));

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/wb_pipe_stage.md
Name: wb_pipe_stage

Overview:
- Parametrised successor to the MEM/WB pipeline register. It is a chain of DEPTH writeback pipeline stages with per-stage valid bits, stall and flush control, and writeback-result selection.
- Provides forwarding-match outputs for the hazard unit and a retired-instruction counter.
- Sits between the memory stage and the register file.

Parameters:
- DATA_W, 32, width of aluout/rd/pcplus4/result.
- ADDR_W, 5, register-file address width.
- DEPTH, 1, number of register stages (legal 1..4); latency in cycles from _m inputs to _w outputs.
- CNT_W, 32, retire-counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold every stage.
- flush  in  1  turn the stage-0 capture into a bubble.
- validm  in  1  memory-stage slot holds a real instruction.
- regwritem  in  1  register write enable.
- memtoregm  in  1  select load data.
- jumplinkm  in  1  select pcplus4 (link).
- rdm  in  DATA_W  load data.
- aluoutm  in  DATA_W  ALU result.
- pcplus4m  in  DATA_W  return address.
- writeregm  in  ADDR_W  destination register.
- rs_addr  in  ADDR_W  decode-stage source A.
- rt_addr  in  ADDR_W  decode-stage source B.
- validw  out  1  final stage valid.
- regwritew  out  1  qualified register-file write enable.
- writeregw  out  ADDR_W  destination register.
- resultw  out  DATA_W  selected writeback data.
- fwd_rs  out  1  final stage will write rs_addr.
- fwd_rt  out  1  final stage will write rt_addr.
- retired  out  CNT_W  instructions retired since reset.

Behaviour:
- Reset (rst_n=0, asynchronous): all stage valid bits, control bits, data fields and retired go to 0. All outputs read 0 while reset is asserted and in the first cycle after release.
- Capture into stage 0 on each clk edge when stall=0:
  - valid = validm & ~flush.
  - regwrite = regwritem & validm & ~flush & (writeregm != 0).
  - Data and address fields are captured unconditionally.
- Stage k (k = 1..DEPTH-1) copies stage k-1 on each edge when stall=0.
- stall=1 with flush=0: every stage holds; inputs are ignored.
- stall=1 with flush=1: stage 0 valid and regwrite clear to 0, its data fields hold; stages 1..DEPTH-1 hold. Flush therefore always kills the stage-0 slot.
- Result select, combinational from the final stage: jumplink ? pcplus4 : (memtoreg ? rd : aluout). jumplink has priority over memtoreg.
- regwritew = final regwrite & final valid. A bubble never writes; register 0 is never written.
- fwd_rs = regwritew & (writeregw == rs_addr) & (rs_addr != 0). fwd_rt is defined the same way with rt_addr. Both are purely combinational.
- retired increments by 1 on each edge where final valid=1 and stall=0. It wraps modulo 2^CNT_W with no saturation and is unaffected by flush.
- Latency is exactly DEPTH clock edges without stall. Each stalled cycle adds one.
- DEPTH=1 reproduces the original single-register behaviour, plus valid/flush/stall and the counter.
- An out-of-range DEPTH is a compile-time error via a generate-time check.

Decomposition:
- Shared package (cpu_pkg):
  - Constants DATA_W_DEF=32, ADDR_W_DEF=5, REG_ZERO=0.
  - Struct typedef wb_fields_t {valid, regwrite, memtoreg, jumplink, rd, aluout, pcplus4, writereg}.
- One sub-module: wb_stage_slot, a single stage register with stall/flush/reset. Instantiate it DEPTH times in a generate loop.
- The result mux, forwarding compare and counter live in the top module.

Test Plan:
- Reset mid-operation: DEPTH=2, stream 3 valid instructions, drop rst_n for 1 ns between edges -> validw=0, resultw=0, retired=0 immediately; the next instruction appears 2 edges after release.
- Result select: aluoutm=0x11, rdm=0x22, pcplus4m=0x33; (memtoreg,jumplink) = 00/10/01/11 -> resultw 0x11/0x22/0x33/0x33 after DEPTH edges.
- Register zero and bubble: regwritem=1, writeregm=0 -> regwritew=0. regwritem=1, writeregm=5, validm=0 -> regwritew=0, retired unchanged.
- Stall/flush: DEPTH=3, stall for 2 cycles mid-stream -> outputs frozen and latency 5. Flush with stall -> that slot emerges with validw=0; older slots unaffected.
- Forwarding: final stage writereg=7, regwrite=1; rs_addr=7, rt_addr=0 -> fwd_rs=1, fwd_rt=0. With rt_addr=7 and the final stage a bubble -> fwd_rt=0.
- Counter wrap: CNT_W=4, retire 17 valid instructions -> retired=1.
